uart_packet_decoder: RTL and testbench
======================================

Name: uart_packet_decoder

Overview:
- Sits directly downstream of the UART receiver and upstream of the ALU/echo execution stage in the UART-ALU datapath.
- Consumes the received byte stream and parses 4-byte packet headers: opcode, reserved, length LSB, length MSB.
- Emits one command descriptor per valid header, then forwards the payload bytes as a stream with a last flag.
- Discards bytes that do not start a valid packet, so the link resynchronises after garbage.

Parameters:
- MaxPayload, 16'd1024, largest payload byte count accepted; any header declaring more is rejected.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- s_axis_tdata_i  in  8  received byte from UART receiver
- s_axis_tvalid_i  in  1  received byte valid
- s_axis_tready_o  out  1  decoder accepts byte
- cmd_valid_o  out  1  header descriptor valid
- cmd_ready_i  in  1  execution stage accepts descriptor
- cmd_opcode_o  out  8  opcode byte
- cmd_len_o  out  16  payload byte count (declared length minus 4)
- m_axis_tdata_o  out  8  payload byte
- m_axis_tvalid_o  out  1  payload byte valid
- m_axis_tready_i  in  1  downstream accepts payload byte
- m_axis_tlast_o  out  1  final payload byte of packet
- err_o  out  1  one-cycle pulse on each rejected byte or header

Behaviour:
- Reset (synchronous, active-high, 1 clk):
  - State goes to IDLE.
  - All outputs go to 0: cmd_*, m_axis_*, err_o, and s_axis_tready_o.
  - Skid buffer is flushed. Reset overrides any in-flight transfer; a partially forwarded packet is abandoned with no tlast.
- Handshakes:
  - AXI-stream rules: a transfer occurs on a rising edge when valid && ready.
  - valid must not drop until ready; data stays stable while valid && !ready.
- Valid opcodes are defined in the package: OP_ECHO=8'hEC, OP_ADD32=8'h10, OP_MUL32=8'h11, OP_DIV32=8'h12.
- IDLE:
  - s_axis_tready_o=1.
  - Valid opcode byte: latch it, go to RSVD.
  - Any other byte: discard it, pulse err_o next cycle, stay in IDLE.
- RSVD: s_axis_tready_o=1. Accept the byte, ignore its value, go to LEN_LO.
- LEN_LO: s_axis_tready_o=1. Latch len[7:0], go to LEN_HI.
- LEN_HI: s_axis_tready_o=1. Latch len[15:8]; the length check happens in the next cycle (CHECK).
- CHECK (1 cycle, s_axis_tready_o=0):
  - If len<4 or len-4>MaxPayload: pulse err_o, go to IDLE.
  - Otherwise: cmd_len_o=len-4, raise cmd_valid_o, go to CMD.
- CMD:
  - Hold cmd_valid_o until cmd_ready_i; s_axis_tready_o=0.
  - On handshake: if cmd_len_o==0 go to IDLE, else load remaining counter = cmd_len_o and go to PAYLOAD.
- PAYLOAD:
  - s_axis_tready_o = skid buffer not full.
  - Each accepted byte is pushed into the skid buffer with last = (remaining==1), and remaining is decremented.
  - When the byte with last=1 is accepted, go to DRAIN.
- DRAIN: s_axis_tready_o=0. Go to IDLE when the skid buffer is empty.
- Payload latency and throughput:
  - 1 clk from s_axis accept to m_axis_tvalid_o.
  - Full throughput of 1 byte/clk when m_axis_tready_i=1.
  - With m_axis_tready_i held low, at most 2 bytes are buffered before s_axis_tready_o drops.
- No timeout: an arbitrarily long gap between bytes inside a packet is legal and must not corrupt parsing.
- cmd_opcode_o/cmd_len_o remain stable from CMD until the next header completes.
- Length arithmetic is 16-bit unsigned. Underflow is excluded by the len<4 check in CHECK.

Decomposition:
- Package uart_alu_pkg holds:
  - opcode localparams (OP_ECHO, OP_ADD32, OP_MUL32, OP_DIV32);
  - HeaderBytes=4;
  - the state enum typedef (IDLE, RSVD, LEN_LO, LEN_HI, CHECK, CMD, PAYLOAD, DRAIN).
- One sub-module, axis_skid_buffer: a 2-entry, 9-bit (data+last) register slice with registered valid/ready.

Test Plan:
- Echo packet: send EC 00 06 00 48 69 -> cmd opcode=EC len=2; payload 48 then 69, tlast only on 69; err_o never pulses.
- Garbage resync: send 00 48, then EC 00 07 00 61 62 63 -> two err_o pulses, no cmd; then cmd EC len=3; payload 61 62 63 with tlast on 63.
- Back-pressure: hold cmd_ready_i=0 for 10 clk and m_axis_tready_i toggling 1/0 on a 10 00 0C 00 + 8-byte packet -> s_axis_tready_o drops during the stall; all 8 bytes delivered in order, none lost or duplicated.
- Zero payload and bad length: send EC 00 04 00 -> cmd len=0 and no payload beat. Then send 11 00 02 00 -> err_o pulse, no cmd. Then send 10 00 FF FF with MaxPayload=1024 -> err_o, no cmd.
- Mid-packet gap: send EC 00 06 00 48, idle 1000 clk, then 69 -> same result as the echo packet.
- Reset mid-payload: assert reset_i after 1 of 2 payload bytes -> next clk all outputs are 0. A following EC 00 05 00 7A parses cleanly with payload 7A, tlast=1.

Source files
------------

// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART-ALU datapath: opcodes, header geometry and
// the packet decoder state encoding.
package uart_alu_pkg;

  localparam logic [7:0] OP_ECHO  = 8'hEC;
  localparam logic [7:0] OP_ADD32 = 8'h10;
  localparam logic [7:0] OP_MUL32 = 8'h11;
  localparam logic [7:0] OP_DIV32 = 8'h12;

  localparam int unsigned HeaderBytes = 4;

  typedef enum logic [2:0] {
    IDLE,
    RSVD,
    LEN_LO,
    LEN_HI,
    CHECK,
    CMD,
    PAYLOAD,
    DRAIN
  } dec_state_e;

  function automatic logic is_valid_opcode(input logic [7:0] op);
    return (op == OP_ECHO) || (op == OP_ADD32) || (op == OP_MUL32) || (op == OP_DIV32);
  endfunction

endpackage

// File: rtl/uart_packet_decoder_if.sv
// Byte-stream, command-descriptor and payload-stream signals of the packet
// decoder; names are relative to the decoder (master = decoder side).
interface uart_packet_decoder_if;

  logic [7:0]  s_axis_tdata_i;
  logic        s_axis_tvalid_i;
  logic        s_axis_tready_o;
  logic        cmd_valid_o;
  logic        cmd_ready_i;
  logic [7:0]  cmd_opcode_o;
  logic [15:0] cmd_len_o;
  logic [7:0]  m_axis_tdata_o;
  logic        m_axis_tvalid_o;
  logic        m_axis_tready_i;
  logic        m_axis_tlast_o;
  logic        err_o;

  modport master (
    input  s_axis_tdata_i, s_axis_tvalid_i, cmd_ready_i, m_axis_tready_i,
    output s_axis_tready_o, cmd_valid_o, cmd_opcode_o, cmd_len_o,
           m_axis_tdata_o, m_axis_tvalid_o, m_axis_tlast_o, err_o
  );

  modport slave (
    output s_axis_tdata_i, s_axis_tvalid_i, cmd_ready_i, m_axis_tready_i,
    input  s_axis_tready_o, cmd_valid_o, cmd_opcode_o, cmd_len_o,
           m_axis_tdata_o, m_axis_tvalid_o, m_axis_tlast_o, err_o
  );

endinterface

// File: rtl/axis_skid_buffer.sv
// Two-entry register slice: a main output register plus one skid register,
// so upstream ready is a pure flop output and throughput is one beat/clk.
module axis_skid_buffer #(
  parameter int DATA_W = 9
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              empty
);

  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              main_vld_q;
  logic              skid_vld_q;
  logic              push;
  logic              pop;

  assign in_ready  = !skid_vld_q;
  assign out_valid = main_vld_q;
  assign out_data  = main_q;
  assign empty     = !main_vld_q && !skid_vld_q;
  assign push      = in_valid && in_ready;
  assign pop       = main_vld_q && out_ready;

  // Skid register only fills when the main register is held by back-pressure.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      main_q     <= '0;
    end else if (skid_vld_q) begin
      if (pop) begin
        main_q     <= skid_q;
        skid_vld_q <= 1'b0;
      end
    end else if (push) begin
      if (!main_vld_q || pop) begin
        main_q     <= in_data;
        main_vld_q <= 1'b1;
      end else begin
        skid_q     <= in_data;
        skid_vld_q <= 1'b1;
      end
    end else if (pop) begin
      main_vld_q <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_packet_decoder.sv
// Parses 4-byte packet headers from the UART byte stream, issues one command
// descriptor per valid header and forwards the payload with a last flag.
module uart_packet_decoder
  import uart_alu_pkg::*;
#(
  parameter logic [15:0] MaxPayload = 16'd1024
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  uart_packet_decoder_if.master bus
);

  dec_state_e  state_q, state_d;
  logic        rdy_en_q;
  logic        err_q, err_d;
  logic [7:0]  hdr_op_q;
  logic [15:0] hdr_len_q;
  logic [7:0]  cmd_op_q;
  logic [15:0] cmd_len_q;
  logic [15:0] rem_q;
  logic [15:0] payload_len;
  logic        hdr_ok;
  logic        s_ready;
  logic        s_acc;
  logic        skid_in_vld;
  logic        skid_in_rdy;
  logic        skid_empty;
  logic [8:0]  skid_out;

  assign payload_len = hdr_len_q - 16'(HeaderBytes);
  assign s_acc       = s_ready && bus.s_axis_tvalid_i;

  always_comb begin
    state_d     = state_q;
    err_d       = 1'b0;
    s_ready     = 1'b0;
    skid_in_vld = 1'b0;
    hdr_ok      = 1'b0;
    case (state_q)
      IDLE: begin
        s_ready = rdy_en_q;
        if (s_ready && bus.s_axis_tvalid_i) begin
          if (is_valid_opcode(bus.s_axis_tdata_i)) state_d = RSVD;
          else                                     err_d   = 1'b1;
        end
      end
      RSVD: begin
        s_ready = rdy_en_q;
        if (s_ready && bus.s_axis_tvalid_i) state_d = LEN_LO;
      end
      LEN_LO: begin
        s_ready = rdy_en_q;
        if (s_ready && bus.s_axis_tvalid_i) state_d = LEN_HI;
      end
      LEN_HI: begin
        s_ready = rdy_en_q;
        if (s_ready && bus.s_axis_tvalid_i) state_d = CHECK;
      end
      // The < check guards the 16-bit subtraction against wrap-around.
      CHECK: begin
        if (hdr_len_q < 16'(HeaderBytes) || payload_len > MaxPayload) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          hdr_ok  = 1'b1;
          state_d = CMD;
        end
      end
      CMD: begin
        if (bus.cmd_ready_i) state_d = (cmd_len_q == 16'd0) ? IDLE : PAYLOAD;
      end
      PAYLOAD: begin
        s_ready     = rdy_en_q && skid_in_rdy;
        skid_in_vld = bus.s_axis_tvalid_i && s_ready;
        if (skid_in_vld && rem_q == 16'd1) state_d = DRAIN;
      end
      DRAIN: begin
        if (skid_empty) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // rdy_en_q keeps s_axis_tready_o low for the first cycle after reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      rdy_en_q  <= 1'b0;
      err_q     <= 1'b0;
      cmd_op_q  <= '0;
      cmd_len_q <= '0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
      err_q    <= err_d;
      if (hdr_ok) begin
        cmd_op_q  <= hdr_op_q;
        cmd_len_q <= payload_len;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (s_acc && state_q == IDLE)   hdr_op_q        <= bus.s_axis_tdata_i;
    if (s_acc && state_q == LEN_LO) hdr_len_q[7:0]  <= bus.s_axis_tdata_i;
    if (s_acc && state_q == LEN_HI) hdr_len_q[15:8] <= bus.s_axis_tdata_i;
    if (state_q == CMD && bus.cmd_ready_i) rem_q <= cmd_len_q;
    else if (skid_in_vld)                  rem_q <= rem_q - 16'd1;
  end

  axis_skid_buffer #(
    .DATA_W(9)
  ) u_skid (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .in_data  ({rem_q == 16'd1, bus.s_axis_tdata_i}),
    .in_valid (skid_in_vld),
    .in_ready (skid_in_rdy),
    .out_data (skid_out),
    .out_valid(bus.m_axis_tvalid_o),
    .out_ready(bus.m_axis_tready_i),
    .empty    (skid_empty)
  );

  assign bus.s_axis_tready_o = s_ready;
  assign bus.cmd_valid_o     = (state_q == CMD);
  assign bus.cmd_opcode_o    = cmd_op_q;
  assign bus.cmd_len_o       = cmd_len_q;
  assign bus.m_axis_tdata_o  = skid_out[7:0];
  assign bus.m_axis_tlast_o  = skid_out[8];
  assign bus.err_o           = err_q;

endmodule

// File: tb/tb_uart_packet_decoder.sv
// Directed bench for uart_packet_decoder: drives header/payload byte vectors
// and compares captured descriptors, payload beats and error pulses.
module tb_uart_packet_decoder;

  logic clk;
  logic reset_i;
  uart_packet_decoder_if bus();

  uart_packet_decoder #(.MaxPayload(16'd1024)) dut (
    .clk_i  (clk),
    .reset_i(reset_i),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int err_cnt = 0;
  int s_stall = 0;
  int cmd_stall = 0;
  int mready_mode = 1;
  int wn;
  int nl;
  logic [8:0]  pay_q[$];
  logic [23:0] cmd_q[$];
  logic [7:0]  tx[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pay_at(input int i);
    if (i < pay_q.size()) return 32'(pay_q[i]);
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] cmd_at(input int i);
    if (i < cmd_q.size()) return 32'(cmd_q[i]);
    return 32'hFFFF_FFFF;
  endfunction

  // Monitor: everything observed on the negative edge, where signals are settled.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.m_axis_tvalid_o && bus.m_axis_tready_i)
        pay_q.push_back({bus.m_axis_tlast_o, bus.m_axis_tdata_o});
      if (bus.cmd_valid_o && bus.cmd_ready_i)
        cmd_q.push_back({bus.cmd_opcode_o, bus.cmd_len_o});
      if (bus.cmd_valid_o && !bus.cmd_ready_i) cmd_stall++;
      if (bus.err_o) err_cnt++;
      if (bus.s_axis_tvalid_i && !bus.s_axis_tready_o) s_stall++;
    end
  end

  // Downstream ready: 0 = held low, 1 = held high, 2 = toggling every clk.
  initial begin
    bus.m_axis_tready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mready_mode)
        0:       bus.m_axis_tready_i = 1'b0;
        1:       bus.m_axis_tready_i = 1'b1;
        default: bus.m_axis_tready_i = ~bus.m_axis_tready_i;
      endcase
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.s_axis_tdata_i  = b;
    bus.s_axis_tvalid_i = 1'b1;
    @(negedge clk);
    while (!bus.s_axis_tready_o && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) chk("send_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    bus.s_axis_tvalid_i = 1'b0;
  endtask

  task automatic send_tx();
    while (tx.size() > 0) send_byte(tx.pop_front());
  endtask

  task automatic clear();
    pay_q.delete();
    cmd_q.delete();
    err_cnt   = 0;
    s_stall   = 0;
    cmd_stall = 0;
  endtask

  initial begin
    reset_i             = 1'b1;
    bus.s_axis_tdata_i  = 8'h00;
    bus.s_axis_tvalid_i = 1'b0;
    bus.cmd_ready_i     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_tready", 32'(bus.s_axis_tready_o), 32'd0);
    chk("rst_cmd_valid", 32'(bus.cmd_valid_o), 32'd0);
    chk("rst_m_tvalid", 32'(bus.m_axis_tvalid_o), 32'd0);
    chk("rst_err", 32'(bus.err_o), 32'd0);
    reset_i = 1'b0;
    wait_cycles(1);
    chk("idle_s_tready", 32'(bus.s_axis_tready_o), 32'd1);
    clear();

    // Echo packet
    tx = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h48, 8'h69};
    send_tx();
    wait_cycles(10);
    chk("echo_ncmd", 32'(cmd_q.size()), 32'd1);
    chk("echo_cmd", cmd_at(0), 32'hEC0002);
    chk("echo_npay", 32'(pay_q.size()), 32'd2);
    chk("echo_pay0", pay_at(0), 32'h048);
    chk("echo_pay1", pay_at(1), 32'h169);
    chk("echo_err", 32'(err_cnt), 32'd0);
    clear();

    // Garbage then resync
    tx = '{8'h00, 8'h48, 8'hEC, 8'h00, 8'h07, 8'h00, 8'h61, 8'h62, 8'h63};
    send_tx();
    wait_cycles(10);
    chk("garb_err", 32'(err_cnt), 32'd2);
    chk("garb_ncmd", 32'(cmd_q.size()), 32'd1);
    chk("garb_cmd", cmd_at(0), 32'hEC0003);
    chk("garb_npay", 32'(pay_q.size()), 32'd3);
    chk("garb_pay0", pay_at(0), 32'h061);
    chk("garb_pay1", pay_at(1), 32'h062);
    chk("garb_pay2", pay_at(2), 32'h163);
    clear();

    // Back-pressure on both the descriptor and the payload stream
    mready_mode     = 2;
    bus.cmd_ready_i = 1'b0;
    wait_cycles(2);
    tx = '{8'h10, 8'h00, 8'h0C, 8'h00, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
    fork
      send_tx();
      begin
        wn = 0;
        do begin
          @(negedge clk);
          wn++;
        end while (!bus.cmd_valid_o && wn < 200);
        if (wn >= 200) chk("bp_cmd_timeout", 32'(wn), 32'd0);
        repeat (10) @(posedge clk);
        #1;
        bus.cmd_ready_i = 1'b1;
      end
    join
    wait_cycles(20);
    mready_mode = 1;
    wait_cycles(2);
    chk("bp_cmd_hold", 32'(cmd_stall), 32'd10);
    chk("bp_s_stall", 32'(s_stall > 0), 32'd1);
    chk("bp_ncmd", 32'(cmd_q.size()), 32'd1);
    chk("bp_cmd", cmd_at(0), 32'h100008);
    chk("bp_npay", 32'(pay_q.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("bp_pay%0d", i), pay_at(i), {23'd0, i == 7, 8'h11 + 8'(i)});
    chk("bp_err", 32'(err_cnt), 32'd0);
    clear();

    // Zero payload
    tx = '{8'hEC, 8'h00, 8'h04, 8'h00};
    send_tx();
    wait_cycles(10);
    chk("zero_cmd", cmd_at(0), 32'hEC0000);
    chk("zero_ncmd", 32'(cmd_q.size()), 32'd1);
    chk("zero_npay", 32'(pay_q.size()), 32'd0);
    chk("zero_err", 32'(err_cnt), 32'd0);
    clear();

    // Declared length below header size
    tx = '{8'h11, 8'h00, 8'h02, 8'h00};
    send_tx();
    wait_cycles(10);
    chk("short_err", 32'(err_cnt), 32'd1);
    chk("short_ncmd", 32'(cmd_q.size()), 32'd0);
    clear();

    // Declared length far above MaxPayload
    tx = '{8'h10, 8'h00, 8'hFF, 8'hFF};
    send_tx();
    wait_cycles(10);
    chk("huge_err", 32'(err_cnt), 32'd1);
    chk("huge_ncmd", 32'(cmd_q.size()), 32'd0);
    clear();

    // One byte over MaxPayload (1029 -> 1025)
    tx = '{8'h10, 8'h00, 8'h05, 8'h04};
    send_tx();
    wait_cycles(10);
    chk("over1_err", 32'(err_cnt), 32'd1);
    chk("over1_ncmd", 32'(cmd_q.size()), 32'd0);
    clear();

    // Exactly MaxPayload (1028 -> 1024)
    tx = '{8'h10, 8'h00, 8'h04, 8'h04};
    for (int i = 0; i < 1024; i++) tx.push_back(8'(i));
    send_tx();
    wait_cycles(10);
    nl = 0;
    foreach (pay_q[i]) if (pay_q[i][8]) nl++;
    chk("max_cmd", cmd_at(0), 32'h100400);
    chk("max_npay", 32'(pay_q.size()), 32'd1024);
    chk("max_pay_first", pay_at(0), 32'h000);
    chk("max_pay_last", pay_at(1023), 32'h1FF);
    chk("max_nlast", 32'(nl), 32'd1);
    chk("max_err", 32'(err_cnt), 32'd0);
    clear();

    // Long gap inside a packet
    tx = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h48};
    send_tx();
    wait_cycles(1000);
    send_byte(8'h69);
    wait_cycles(10);
    chk("gap_cmd", cmd_at(0), 32'hEC0002);
    chk("gap_npay", 32'(pay_q.size()), 32'd2);
    chk("gap_pay0", pay_at(0), 32'h048);
    chk("gap_pay1", pay_at(1), 32'h169);
    chk("gap_err", 32'(err_cnt), 32'd0);
    clear();

    // Reset in the middle of a payload
    mready_mode = 0;
    wait_cycles(2);
    tx = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h48};
    send_tx();
    chk("mid_m_tvalid_pre", 32'(bus.m_axis_tvalid_o), 32'd1);
    reset_i = 1'b1;
    wait_cycles(1);
    chk("mid_rst_s_tready", 32'(bus.s_axis_tready_o), 32'd0);
    chk("mid_rst_cmd_valid", 32'(bus.cmd_valid_o), 32'd0);
    chk("mid_rst_cmd_op", 32'(bus.cmd_opcode_o), 32'd0);
    chk("mid_rst_cmd_len", 32'(bus.cmd_len_o), 32'd0);
    chk("mid_rst_m_tvalid", 32'(bus.m_axis_tvalid_o), 32'd0);
    chk("mid_rst_m_tdata", 32'(bus.m_axis_tdata_o), 32'd0);
    chk("mid_rst_m_tlast", 32'(bus.m_axis_tlast_o), 32'd0);
    chk("mid_rst_err", 32'(bus.err_o), 32'd0);
    reset_i     = 1'b0;
    mready_mode = 1;
    wait_cycles(3);
    chk("mid_npay_abandoned", 32'(pay_q.size()), 32'd0);
    clear();
    tx = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h7A};
    send_tx();
    wait_cycles(10);
    chk("post_cmd", cmd_at(0), 32'hEC0001);
    chk("post_npay", 32'(pay_q.size()), 32'd1);
    chk("post_pay0", pay_at(0), 32'h17A);
    chk("post_err", 32'(err_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
